sirv_pmu_unlock_ctrl: RTL and testbench
=======================================

# sirv_pmu_unlock_ctrl

Key-based unlock controller for the PMU register block. It watches writes to the PMU key register and, on the magic key, opens a one-shot, time-limited unlock window. The PMU core's write-enable logic consumes `unlocked` to gate each protected register write. The block also counts bad-key attempts and enforces a lockout after repeated failures. It sits between the PMU register-bus decode and the PMU core's protected-write gating.

## Interface
Parameters:
- `KEY_VALUE`, default 32'h0051_F15E: magic unlock key.
- `UNLOCK_TIMEOUT`, default 64: cycles the window stays open without a consuming write (≥2).
- `MAX_FAILS`, default 3: consecutive bad keys that trigger lockout (1..15).
- `LOCKOUT_CYCLES`, default 1024: lockout duration (≥2).

Ports:
- `clock`  in  1  — single clock.
- `rst_n`  in  1  — synchronous reset, active-low.
- `io_regs_key_write_valid`  in  1  — write strobe for the key register.
- `io_regs_key_write_bits`  in  32  — key register write data.
- `io_regs_prot_write_valid`  in  1  — write attempt to any protected PMU register.
- `unlocked`  out  1  — window open; registered.
- `io_prot_write_accept`  out  1  — combinational: `io_regs_prot_write_valid & unlocked`.
- `io_regs_key_read_bits`  out  32  — `{29'b0, lockout, fail_cnt_sat, unlocked}`.
- `lock_violation`  out  1  — registered one-cycle pulse when a protected write is rejected.
- `fail_count`  out  4  — consecutive bad-key count.

## Operation
- States: LOCKED, UNLOCKED, LOCKOUT. Reset enters LOCKED.
- Reset values: `unlocked`=0, `fail_count`=0, `lock_violation`=0, all timers 0.

LOCKED:
- Key write with data == `KEY_VALUE`: go to UNLOCKED, clear `fail_count`, load the window timer with `UNLOCK_TIMEOUT-1`.
- Key write with any other data: increment `fail_count`. When the count reaches `MAX_FAILS`, go to LOCKOUT, load the lockout timer with `LOCKOUT_CYCLES-1`, and clear `fail_count`.
- A protected write is rejected and `lock_violation` pulses.

UNLOCKED:
- A protected write is accepted and consumes the window: go to LOCKED.
- The timer decrements each cycle. At timer == 0 with no write, go to LOCKED.
- A correct key write reloads the timer.
- An incorrect key write closes the window (go to LOCKED) and counts as a failure.

LOCKOUT:
- All key writes are ignored and are not counted.
- Protected writes are rejected and `lock_violation` pulses.
- At timer == 0, go to LOCKED.

Simultaneous events:
- A protected write and a key write in the same cycle while UNLOCKED: the protected write is accepted and consumes the window. The key write is discarded, with no reload and no failure count.
- A protected write and a correct key write in the same cycle while LOCKED: the protected write is rejected, because `unlocked` is still 0 that cycle. The window opens next cycle.

Other rules:
- No other input (debug mode, privilege, test mode) opens or extends the window. The only path to UNLOCKED is the key compare.
- `fail_count` is 4 bits and saturates at `MAX_FAILS`. `fail_cnt_sat` = (`fail_count` == `MAX_FAILS`-1).
- Timer widths are `$clog2` of the respective parameter. Timers never wrap.

## Timing
- Key write in cycle N: `unlocked` = 1 from cycle N+1.
- Accepted protected write in cycle M: `io_prot_write_accept` = 1 in cycle M and `unlocked` = 0 from M+1. Exactly one protected write is accepted per unlock.
- The window with no consuming write lasts exactly `UNLOCK_TIMEOUT` cycles: `unlocked` is high for cycles N+1 .. N+`UNLOCK_TIMEOUT`.
- Lockout lasts exactly `LOCKOUT_CYCLES` cycles from the cycle after the triggering bad key.
- `lock_violation` asserts in the cycle after the rejected write, for one cycle.
- `rst_n` low mid-window or mid-lockout: LOCKED on the next edge, with all counters cleared.

## Structure
- Shared package `sirv_pmu_pkg`:
  - state enum `pmu_unlock_state_e` {LOCKED, UNLOCKED, LOCKOUT};
  - `PMU_KEY_VALUE` constant;
  - key-register read bit positions.
- Natural sub-module: `sirv_pmu_down_timer`, a loadable down-counter with a zero flag. It is instantiated twice, for the window timer and the lockout timer.
- The FSM, fail counter and output logic live in the top module.

## Test plan
- Correct key 32'h0051_F15E in cycle 10, protected write in cycle 15 → accept=1 in cycle 15, `unlocked` 0 from 16, and a second protected write in 17 is rejected with `lock_violation` in 18.
- Correct key, then no writes → `unlocked` high for exactly 64 cycles, then low. A protected write in cycle 65 after the key is rejected.
- Three bad keys (32'h0) → `fail_count` goes 1, 2, then LOCKOUT. The correct key during lockout leaves `unlocked`=0. After 1024 cycles the correct key unlocks.
- Protected write and key write in the same cycle, in both LOCKED and UNLOCKED → behaviour matches the simultaneous-event rules above, and `fail_count` is unchanged.
- `rst_n` low for one cycle mid-window and mid-lockout → all outputs at reset values next cycle. A protected write immediately after is rejected.
- Random protected writes with no key ever written → accept never asserts, and every attempt yields one `lock_violation` pulse.

Source files
------------

// File: rtl/sirv_pmu_pkg.sv
// Shared definitions for the PMU key-unlock logic.
package sirv_pmu_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        LOCKOUT  = 2'd2
    } pmu_unlock_state_e;

    localparam logic [31:0] PMU_KEY_VALUE = 32'h0051_F15E;

    // Bit positions in the key register read-back word
    localparam int unsigned KEY_RD_UNLOCKED_BIT = 0;
    localparam int unsigned KEY_RD_FAILSAT_BIT  = 1;
    localparam int unsigned KEY_RD_LOCKOUT_BIT  = 2;

endpackage

// File: rtl/sirv_pmu_down_timer.sv
// Loadable down-counter that stops at zero and flags it.
module sirv_pmu_down_timer #(
    parameter int unsigned WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear beats load beats decrement; decrement holds at zero
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Count register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sirv_pmu_unlock_ctrl.sv
// Key-based unlock controller: one-shot, time-limited write window for
// protected PMU registers, with bad-key counting and lockout.
module sirv_pmu_unlock_ctrl
    import sirv_pmu_pkg::*;
#(
    parameter logic [31:0] KEY_VALUE      = PMU_KEY_VALUE,
    parameter int unsigned UNLOCK_TIMEOUT = 64,
    parameter int unsigned MAX_FAILS      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        io_regs_key_write_valid,
    input  logic [31:0] io_regs_key_write_bits,
    input  logic        io_regs_prot_write_valid,
    output logic        unlocked,
    output logic        io_prot_write_accept,
    output logic [31:0] io_regs_key_read_bits,
    output logic        lock_violation,
    output logic [3:0]  fail_count
);

    localparam int unsigned WIN_W = $clog2(UNLOCK_TIMEOUT);
    localparam int unsigned LO_W  = $clog2(LOCKOUT_CYCLES);

    localparam logic [WIN_W-1:0] WIN_LOAD  = WIN_W'(UNLOCK_TIMEOUT - 1);
    localparam logic [LO_W-1:0]  LO_LOAD   = LO_W'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]       FAIL_MAX  = 4'(MAX_FAILS);
    localparam logic [3:0]       FAIL_SAT  = 4'(MAX_FAILS - 1);

    pmu_unlock_state_e state_d, state_q;
    logic [3:0]        fail_d, fail_q;
    logic              unlocked_d, unlocked_q;
    logic              viol_d, viol_q;

    logic       key_ok, key_bad;
    logic [3:0] fail_inc;
    logic       fail_trip;
    logic       win_clear, win_load, win_zero;
    logic       lo_load, lo_zero;

    sirv_pmu_down_timer #(
        .WIDTH(WIN_W)
    ) u_win_timer (
        .clk      (clock),
        .rst_n    (rst_n),
        .clear    (win_clear),
        .load     (win_load),
        .load_val (WIN_LOAD),
        .dec      (state_q == UNLOCKED),
        .zero     (win_zero)
    );

    sirv_pmu_down_timer #(
        .WIDTH(LO_W)
    ) u_lockout_timer (
        .clk      (clock),
        .rst_n    (rst_n),
        .clear    (1'b0),
        .load     (lo_load),
        .load_val (LO_LOAD),
        .dec      (state_q == LOCKOUT),
        .zero     (lo_zero)
    );

    // Next-state, fail counter and timer control
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        win_clear = 1'b0;
        win_load  = 1'b0;
        lo_load   = 1'b0;

        key_ok    = io_regs_key_write_valid && (io_regs_key_write_bits == KEY_VALUE);
        key_bad   = io_regs_key_write_valid && (io_regs_key_write_bits != KEY_VALUE);
        fail_inc  = (fail_q >= FAIL_MAX) ? FAIL_MAX : fail_q + 4'd1;
        fail_trip = (fail_inc == FAIL_MAX);

        case (state_q)
            LOCKED: begin
                if (key_ok) begin
                    state_d  = UNLOCKED;
                    fail_d   = '0;
                    win_load = 1'b1;
                end else if (key_bad) begin
                    if (fail_trip) begin
                        state_d = LOCKOUT;
                        lo_load = 1'b1;
                        fail_d  = '0;
                    end else begin
                        fail_d  = fail_inc;
                    end
                end
            end
            UNLOCKED: begin
                // A consuming protected write wins over any same-cycle key write
                if (io_regs_prot_write_valid) begin
                    state_d   = LOCKED;
                    win_clear = 1'b1;
                end else if (key_ok) begin
                    win_load  = 1'b1;
                end else if (key_bad) begin
                    win_clear = 1'b1;
                    if (fail_trip) begin
                        state_d = LOCKOUT;
                        lo_load = 1'b1;
                        fail_d  = '0;
                    end else begin
                        state_d = LOCKED;
                        fail_d  = fail_inc;
                    end
                end else if (win_zero) begin
                    state_d = LOCKED;
                end
            end
            LOCKOUT: begin
                if (lo_zero) begin
                    state_d = LOCKED;
                end
            end
            default: begin
                state_d = LOCKED;
            end
        endcase

        unlocked_d = (state_d == UNLOCKED);
        viol_d     = io_regs_prot_write_valid && !unlocked_q;
    end

    // FSM state and registered outputs
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q    <= LOCKED;
            fail_q     <= '0;
            unlocked_q <= 1'b0;
            viol_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            unlocked_q <= unlocked_d;
            viol_q     <= viol_d;
        end
    end

    assign unlocked             = unlocked_q;
    assign lock_violation       = viol_q;
    assign fail_count           = fail_q;
    assign io_prot_write_accept = io_regs_prot_write_valid && unlocked_q;

    // Key register read-back word
    always_comb begin
        io_regs_key_read_bits                      = '0;
        io_regs_key_read_bits[KEY_RD_UNLOCKED_BIT] = unlocked_q;
        io_regs_key_read_bits[KEY_RD_FAILSAT_BIT]  = (fail_q == FAIL_SAT);
        io_regs_key_read_bits[KEY_RD_LOCKOUT_BIT]  = (state_q == LOCKOUT);
    end

endmodule

// File: tb/tb_sirv_pmu_unlock_ctrl.sv
// Directed bench for sirv_pmu_unlock_ctrl with default-sized parameters.
module tb_sirv_pmu_unlock_ctrl;

    localparam logic [31:0] KEY = 32'h0051_F15E;

    logic        clock = 1'b0;
    logic        rst_n;
    logic        key_valid;
    logic [31:0] key_bits;
    logic        prot_valid;
    logic        unlocked;
    logic        accept;
    logic [31:0] key_rd;
    logic        viol;
    logic [3:0]  fail_count;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clock = ~clock;

    sirv_pmu_unlock_ctrl #(
        .KEY_VALUE      (KEY),
        .UNLOCK_TIMEOUT (64),
        .MAX_FAILS      (3),
        .LOCKOUT_CYCLES (1024)
    ) dut (
        .clock                    (clock),
        .rst_n                    (rst_n),
        .io_regs_key_write_valid  (key_valid),
        .io_regs_key_write_bits   (key_bits),
        .io_regs_prot_write_valid (prot_valid),
        .unlocked                 (unlocked),
        .io_prot_write_accept     (accept),
        .io_regs_key_read_bits    (key_rd),
        .lock_violation           (viol),
        .fail_count               (fail_count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic key_write(input logic [31:0] data);
        key_valid = 1'b1;
        key_bits  = data;
        tick();
        key_valid = 1'b0;
        key_bits  = '0;
    endtask

    int unsigned hi_cnt;
    int unsigned att_cnt;
    int unsigned acc_cnt;
    int unsigned vio_cnt;

    initial begin
        rst_n      = 1'b0;
        key_valid  = 1'b0;
        key_bits   = '0;
        prot_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // Reset state
        check("rst_unlocked", 32'(unlocked), 32'd0);
        check("rst_fail", 32'(fail_count), 32'd0);
        check("rst_viol", 32'(viol), 32'd0);
        check("rst_rd", key_rd, 32'h0);

        // One-shot consumption
        key_write(KEY);
        check("key_opens", 32'(unlocked), 32'd1);
        check("key_rd_open", key_rd, 32'h1);
        repeat (4) tick();
        check("still_open", 32'(unlocked), 32'd1);
        prot_valid = 1'b1;
        #1;
        check("accept_first", 32'(accept), 32'd1);
        tick();
        prot_valid = 1'b0;
        check("closed_after_use", 32'(unlocked), 32'd0);
        check("no_viol_on_accept", 32'(viol), 32'd0);
        tick();
        prot_valid = 1'b1;
        #1;
        check("reject_second", 32'(accept), 32'd0);
        tick();
        prot_valid = 1'b0;
        check("viol_second", 32'(viol), 32'd1);
        tick();
        check("viol_one_cycle", 32'(viol), 32'd0);

        // Window timeout
        key_write(KEY);
        hi_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (unlocked) hi_cnt++;
            tick();
        end
        check("window_len", hi_cnt, 32'd64);
        check("window_closed", 32'(unlocked), 32'd0);
        prot_valid = 1'b1;
        #1;
        check("late_reject", 32'(accept), 32'd0);
        tick();
        prot_valid = 1'b0;
        check("late_viol", 32'(viol), 32'd1);

        // Bad keys and lockout
        key_write(32'h0);
        check("fail1", 32'(fail_count), 32'd1);
        check("fail1_rd", key_rd, 32'h0);
        key_write(32'h0);
        check("fail2", 32'(fail_count), 32'd2);
        check("fail2_rd_sat", key_rd, 32'h2);
        key_write(32'h0);
        check("lockout_fail", 32'(fail_count), 32'd0);
        check("lockout_rd", key_rd, 32'h4);
        key_write(KEY);
        check("lockout_key_ignored", 32'(unlocked), 32'd0);
        key_write(32'hDEAD_BEEF);
        check("lockout_bad_not_counted", 32'(fail_count), 32'd0);
        prot_valid = 1'b1;
        #1;
        check("lockout_reject", 32'(accept), 32'd0);
        tick();
        prot_valid = 1'b0;
        check("lockout_viol", 32'(viol), 32'd1);
        repeat (1020) tick();
        check("lockout_last_cycle", key_rd, 32'h4);
        tick();
        check("lockout_over", key_rd, 32'h0);
        key_write(KEY);
        check("unlock_after_lockout", 32'(unlocked), 32'd1);

        // Simultaneous in UNLOCKED: prot write wins, bad key discarded
        key_valid  = 1'b1;
        key_bits   = 32'h0;
        prot_valid = 1'b1;
        #1;
        check("sim_unl_accept", 32'(accept), 32'd1);
        tick();
        key_valid  = 1'b0;
        prot_valid = 1'b0;
        check("sim_unl_closed", 32'(unlocked), 32'd0);
        check("sim_unl_fail", 32'(fail_count), 32'd0);

        // Simultaneous in UNLOCKED with correct key: no reload
        key_write(KEY);
        key_valid  = 1'b1;
        key_bits   = KEY;
        prot_valid = 1'b1;
        #1;
        check("sim_unl2_accept", 32'(accept), 32'd1);
        tick();
        key_valid  = 1'b0;
        prot_valid = 1'b0;
        check("sim_unl2_closed", 32'(unlocked), 32'd0);

        // Simultaneous in LOCKED: write rejected, window opens next cycle
        key_valid  = 1'b1;
        key_bits   = KEY;
        prot_valid = 1'b1;
        #1;
        check("sim_lck_reject", 32'(accept), 32'd0);
        tick();
        key_valid  = 1'b0;
        prot_valid = 1'b0;
        check("sim_lck_open", 32'(unlocked), 32'd1);
        check("sim_lck_viol", 32'(viol), 32'd1);
        check("sim_lck_fail", 32'(fail_count), 32'd0);

        // Reset mid-window
        repeat (3) tick();
        do_reset();
        check("rstw_unlocked", 32'(unlocked), 32'd0);
        check("rstw_rd", key_rd, 32'h0);
        check("rstw_viol", 32'(viol), 32'd0);
        prot_valid = 1'b1;
        #1;
        check("rstw_reject", 32'(accept), 32'd0);
        tick();
        prot_valid = 1'b0;
        check("rstw_viol_after", 32'(viol), 32'd1);

        // Reset mid-lockout
        repeat (3) key_write(32'h1234);
        check("rstl_in_lockout", key_rd, 32'h4);
        repeat (10) tick();
        do_reset();
        check("rstl_rd", key_rd, 32'h0);
        check("rstl_fail", 32'(fail_count), 32'd0);
        prot_valid = 1'b1;
        #1;
        check("rstl_reject", 32'(accept), 32'd0);
        tick();
        prot_valid = 1'b0;
        check("rstl_viol", 32'(viol), 32'd1);
        key_write(KEY);
        check("rstl_key_opens", 32'(unlocked), 32'd1);

        // Random protected writes with no key
        do_reset();
        att_cnt = 0;
        acc_cnt = 0;
        vio_cnt = 0;
        for (int i = 0; i < 200; i++) begin
            prot_valid = 1'($urandom_range(0, 1));
            #1;
            if (accept) acc_cnt++;
            if (prot_valid) att_cnt++;
            tick();
            if (viol) vio_cnt++;
        end
        prot_valid = 1'b0;
        check("rand_no_accept", acc_cnt, 32'd0);
        check("rand_viol_count", vio_cnt, att_cnt);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
